// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder: one symbolic request per handshake in,
// one 32-bit machine word plus its byte address out, through a single output
// register. Branch offsets and jump fields are resolved against a running PC.
module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_word_q, out_word_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic        out_err_q, out_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        accept;
    logic [31:0] pc_plus4;
    logic [31:0] br_diff;
    logic        br_ok;
    logic        j_ok;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] enc_word;
    logic        enc_err;

    assign in_ready = ~reset & ~restart & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // Combinational encode of the presented request against the current PC.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_diff  = in_target - pc_plus4;
        // The word offset is br_diff >>> 2; it fits 16 bits exactly when the
        // top 15 bits of the byte difference are all copies of the sign.
        br_ok    = (br_diff[1:0] == 2'b00) &&
                   ((&br_diff[31:17]) || ~(|br_diff[31:17]));
        j_ok     = (in_target[1:0] == 2'b00) &&
                   (in_target[31:28] == pc_plus4[31:28]);
        funct    = 6'h00;
        opcode   = 6'h00;
        enc_word = 32'h0000_0000;
        enc_err  = 1'b0;
        case (in_mnem)
            5'd0:  funct = 6'h20;
            5'd1:  funct = 6'h21;
            5'd2:  funct = 6'h22;
            5'd3:  funct = 6'h23;
            5'd4:  funct = 6'h24;
            5'd5:  funct = 6'h25;
            5'd6:  funct = 6'h26;
            5'd7:  funct = 6'h27;
            5'd8:  funct = 6'h2A;
            5'd9:  funct = 6'h2B;
            5'd10: opcode = 6'h08;
            5'd11: opcode = 6'h09;
            5'd12: opcode = 6'h0C;
            5'd13: opcode = 6'h0D;
            5'd14: opcode = 6'h0A;
            5'd15: opcode = 6'h0B;
            5'd16: opcode = 6'h23;
            5'd17: opcode = 6'h2B;
            5'd18: opcode = 6'h04;
            5'd19: opcode = 6'h05;
            5'd20: opcode = 6'h02;
            default: enc_err = 1'b1;
        endcase
        if (in_mnem <= 5'd9) begin
            enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b00000, funct};
        end else if (in_mnem <= 5'd17) begin
            enc_word = {opcode, in_rs, in_rt, in_imm};
        end else if (in_mnem <= 5'd19) begin
            enc_err  = ~br_ok;
            enc_word = {opcode, in_rs, in_rt, br_diff[17:2]};
        end else if (in_mnem == 5'd20) begin
            enc_err  = ~j_ok;
            enc_word = {opcode, in_target[27:2]};
        end
        if (enc_err) begin
            enc_word = 32'h0000_0000;
        end
    end

    // Next-state: load on accept, drain when consumed, restart rewinds the PC.
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_word_d  = enc_word;
            out_addr_d  = pc_q;
            out_err_d   = enc_err;
            pc_d        = pc_plus4;
            if (enc_err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (restart) begin
            pc_d = BASE_ADDR;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= BASE_ADDR;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0000_0000;
            out_addr_q  <= 32'h0000_0000;
            out_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: fixed vector table, hand-written handshake
// sequences and a randomized run, all checked against a cycle model.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [31:0] in_target, out_word, out_addr;
    logic [7:0]  err_count;

    mips_instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] FUNCT [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                          6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    localparam logic [5:0] OPS [11] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B,
                                        6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_word = '0, m_addr = '0, m_pc = '0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_enc(input int mn, input int rs, input int rt, input int rd,
                                      input logic [15:0] imm, input logic [31:0] tgt,
                                      input logic [31:0] pc,
                                      output logic [31:0] w, output logic e);
        logic [31:0] pc4;
        int diff, off;
        pc4 = pc + 32'd4;
        e = 1'b0;
        w = 32'h0;
        if (mn < 10) begin
            w = 32'(FUNCT[mn]) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
        end else if (mn <= 17) begin
            w = (32'(OPS[mn-10]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        end else if (mn <= 19) begin
            diff = int'(tgt) - int'(pc4);
            off  = diff >>> 2;
            e = (tgt % 4 != 0) || (off < -32768) || (off > 32767);
            w = (32'(OPS[mn-10]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                (32'(off) & 32'h0000_FFFF);
        end else if (mn == 20) begin
            e = (tgt % 4 != 0) || ((tgt >> 28) != (pc4 >> 28));
            w = 32'h0800_0000 | ((tgt & 32'h0FFF_FFFC) >> 2);
        end else begin
            e = 1'b1;
        end
        if (e) w = 32'h0;
    endfunction

    // One clock cycle: drive inputs, check in_ready, advance the model,
    // then check the registered outputs half a cycle after the edge.
    task automatic step(input logic v, input int mn, input int rs, input int rt, input int rd,
                        input logic [15:0] imm, input logic [31:0] tgt,
                        input logic ordy, input logic rst, input logic rstrt);
        logic exp_ready, acc, e;
        logic [31:0] w;
        in_valid = v; in_mnem = 5'(mn); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = imm; in_target = tgt; out_ready = ordy; reset = rst; restart = rstrt;
        #1;
        exp_ready = !rst && !rstrt && (!m_valid || ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        acc = v && exp_ready;
        if (rst) begin
            m_valid = 0; m_word = 0; m_addr = 0; m_err = 0; m_cnt = 0; m_pc = 0;
        end else begin
            if (acc) begin
                model_enc(mn, rs, rt, rd, imm, tgt, m_pc, w, e);
                m_valid = 1; m_word = w; m_addr = m_pc; m_err = e;
                m_pc = m_pc + 32'd4;
                if (e && m_cnt < 255) m_cnt++;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
            if (rstrt) m_pc = 32'h0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("err_count", {24'b0, err_count}, 32'(m_cnt));
        if (m_valid) begin
            chk("out_word", out_word, m_word);
            chk("out_addr", out_addr, m_addr);
            chk("out_err", {31'b0, out_err}, {31'b0, m_err});
        end
    endtask

    typedef struct {
        int          mn, rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] tgt;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{0,  1,  2,  3,  16'h0000, 32'h0,         32'h0022_1820, 1'b0};
        tbl[1]  = '{10, 0,  8,  0,  16'h0005, 32'h0,         32'h2008_0005, 1'b0};
        tbl[2]  = '{17, 29, 9,  0,  16'h0004, 32'h0,         32'hAFA9_0004, 1'b0};
        tbl[3]  = '{7,  4,  5,  6,  16'h0000, 32'h0,         32'h0085_3027, 1'b0};
        tbl[4]  = '{18, 1,  2,  0,  16'h0000, 32'h0000_0008, 32'h1022_FFFD, 1'b0};
        tbl[5]  = '{20, 0,  0,  0,  16'h0000, 32'h0040_0000, 32'h0810_0000, 1'b0};
        tbl[6]  = '{25, 1,  2,  3,  16'h1234, 32'h0,         32'h0000_0000, 1'b1};
        tbl[7]  = '{19, 1,  2,  0,  16'h0000, 32'h0000_0009, 32'h0000_0000, 1'b1};
        tbl[8]  = '{18, 1,  2,  0,  16'h0000, 32'h0002_0024, 32'h0000_0000, 1'b1};
        tbl[9]  = '{18, 3,  4,  0,  16'h0000, 32'h0000_0028, 32'h1064_0000, 1'b0};
        tbl[10] = '{19, 0,  0,  0,  16'h0000, 32'h0002_0028, 32'h1400_7FFF, 1'b0};
        tbl[11] = '{18, 0,  0,  0,  16'h0000, 32'hFFFE_0030, 32'h1000_8000, 1'b0};
        tbl[12] = '{20, 0,  0,  0,  16'h0000, 32'h1000_0000, 32'h0000_0000, 1'b1};
        tbl[13] = '{16, 29, 8,  0,  16'hFFFC, 32'h0,         32'h8FA8_FFFC, 1'b0};
        tbl[14] = '{9,  31, 31, 31, 16'h0000, 32'h0,         32'h03FF_F82B, 1'b0};
        tbl[15] = '{15, 7,  0,  0,  16'h8000, 32'h0,         32'h2CE0_8000, 1'b0};
        tbl[16] = '{31, 0,  0,  0,  16'h0000, 32'h0,         32'h0000_0000, 1'b1};

        reset = 1; restart = 0; in_valid = 0; out_ready = 1;
        in_mnem = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_target = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 16'h0, 32'h0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 16'h0, 32'h0, 1, 1, 0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_word", out_word, 32'h0);
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_errcnt", {24'b0, err_count}, 32'd0);

        // vector table streamed back to back: addresses must step by 4 each cycle
        for (int i = 0; i < 17; i++) begin
            step(1, tbl[i].mn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tgt, 1, 0, 0);
            chk($sformatf("tbl%0d_word", i), out_word, tbl[i].word);
            chk($sformatf("tbl%0d_err", i), {31'b0, out_err}, {31'b0, tbl[i].err});
            chk($sformatf("tbl%0d_addr", i), out_addr, 32'(i * 4));
        end
        chk("tbl_errcnt", {24'b0, err_count}, 32'd5);

        // backpressure: word held stable for 3 stalled cycles, then drain+accept
        step(1, 0, 1, 2, 3, 16'h0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 13, 1, 2, 0, 16'h00FF, 32'h0, 0, 0, 0);
            chk("bp_hold_word", out_word, 32'h0022_1820);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
        end
        step(1, 13, 1, 2, 0, 16'h00FF, 32'h0, 1, 0, 0);
        chk("bp_release_word", out_word, 32'h3422_00FF);
        chk("bp_release_valid", {31'b0, out_valid}, 32'd1);

        // restart with a word pending, then reset with a word pending
        step(1, 0, 1, 2, 3, 16'h0, 32'h0, 0, 0, 1);
        chk("rs_pending_word", out_word, 32'h3422_00FF);
        step(1, 0, 1, 2, 3, 16'h0, 32'h0, 1, 0, 0);
        chk("rs_addr_base", out_addr, 32'h0);
        chk("rs_word", out_word, 32'h0022_1820);
        step(1, 2, 1, 2, 3, 16'h0, 32'h0, 0, 0, 0);
        step(1, 2, 1, 2, 3, 16'h0, 32'h0, 0, 1, 0);
        chk("rst2_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_errcnt", {24'b0, err_count}, 32'd0);
        step(1, 0, 1, 2, 3, 16'h0, 32'h0, 1, 0, 0);
        chk("rst2_addr_base", out_addr, 32'h0);

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            int          sel, o;
            logic [31:0] tgt;
            logic [31:0] pc4;
            pc4 = m_pc + 32'd4;
            sel = int'($urandom_range(0, 3));
            o   = int'($urandom_range(0, 80000)) - 40000;
            case (sel)
                0: tgt = pc4 + 32'(o * 4);
                1: tgt = $urandom;
                2: tgt = pc4 + 32'(o);
                default: tgt = {pc4[31:28], 28'($urandom) & 28'hFFF_FFFC};
            endcase
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), 16'($urandom), tgt,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Streaming MIPS instruction encoder: accepts one symbolic instruction per handshake (mnemonic code, register fields, immediate, target byte address) and emits the 32-bit machine word with its instruction address. It covers the same instruction subset the single-cycle control unit decodes, and it loads instruction memory and generates verification stimulus for the lab datapath. Branch offsets and jump fields are computed from a running PC, and malformed requests are flagged.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted instruction
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- restart  in  1  reload PC to BASE_ADDR (synchronous)
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept
- in_mnem  in  5  mnemonic code (below)
- in_rs, in_rt, in_rd  in  5 each  register numbers
- in_imm  in  16  immediate (I-type, LW/SW)
- in_target  in  32  absolute byte target (BEQ/BNE/J)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_word  out  32  machine word
- out_addr  out  32  byte address of out_word
- out_err  out  1  this word is an error substitute (NOP)
- err_count  out  8  saturating error count

## Operation
- Mnemonic map (R-type funct): 0 ADD 20, 1 ADDU 21, 2 SUB 22, 3 SUBU 23, 4 AND 24, 5 OR 25, 6 XOR 26, 7 NOR 27, 8 SLT 2A, 9 SLTU 2B.
- I-type opcodes: 10 ADDI 08, 11 ADDIU 09, 12 ANDI 0C, 13 ORI 0D, 14 SLTI 0A, 15 SLTIU 0B, 16 LW 23, 17 SW 2B, 18 BEQ 04, 19 BNE 05, 20 J 02. Codes 21–31 are illegal.
- R-type: {6'h00, rs, rt, rd, 5'b0, funct}. I-type/LW/SW: {op, rs, rt, imm}. in_rd is ignored outside R-type.
- BEQ/BNE: diff = in_target − (pc+4), computed in 32-bit two's complement. off = diff>>>2. Word is {op, rs, rt, off[15:0]}.
  - Error if in_target[1:0]≠0 or off is outside [−32768, 32767].
- J: {6'h02, in_target[27:2]}.
  - Error if in_target[1:0]≠0 or in_target[31:28]≠(pc+4)[31:28].
- Any error (illegal code, bad branch, bad jump): out_word=32'h0000_0000, out_err=1. On each such accept, err_count increments and saturates at 255.
- pc register: the address assigned to the accepted instruction. pc advances by 4 on every accept, including errored ones, and wraps modulo 2^32.

## Timing
- Single output register with a one-entry hold. in_ready = ~reset & ~restart & (~out_valid | out_ready), purely combinational.
- Accept = in_valid & in_ready. Latency is one cycle: on the edge after an accept, out_valid=1 and out_word/out_addr/out_err reflect that request.
- Full throughput: back-to-back accepts when out_ready stays high.
- Stall: while out_valid & ~out_ready, the outputs hold stable and in_ready=0.
- out_valid clears on the edge where out_valid & out_ready and there is no new accept.
- restart: PC←BASE_ADDR on the next edge. A pending output word is still presented and drained normally. No accept happens in a restart cycle.
- reset (priority over all): out_valid=0, out_word=0, out_addr=0, out_err=0, err_count=0, pc=BASE_ADDR. Any held word is discarded, and in_ready=0 during reset.
- Simultaneous drain and accept: the new word replaces the old one on the same edge, with no bubble.
- Branch range is checked on the full 32-bit diff, with no truncation before the check. A target equal to pc+4 gives off=0.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 with out_ready=1 → next cycle out_word=0x00221820, out_addr=0x0, out_err=0, in_ready stays high.
- Stream ADDI rt=8 rs=0 imm=5, then SW rt=9 rs=29 imm=4, back to back → 0x20080005 @0x0, 0xAFA90004 @0x4, with no bubbles.
- PC at 0x10: BEQ rs=1 rt=2 target=0x08 → 0x1022FFFD @0x10. Then J target=0x0040_0000 → 0x08100000.
- Errors:
  - Illegal code 25 → word 0x00000000, out_err=1, err_count=1, PC still advances by 4.
  - BNE with target=0x09 → NOP, err_count=2.
  - BEQ with target=pc+4+0x20000 → NOP.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → out_word stable and in_ready=0. Release → the pending word drains and the next request is accepted on the same edge.
- Apply restart, then reset, mid-stream with a word held → after restart the next address is BASE_ADDR. After reset out_valid=0 and err_count=0.
